alu: RTL and testbench
======================

// Module: alu
//
// PURPOSE
// - Registered 8-bit arithmetic/logic unit: combines operands a and b per 2-bit opcode op.
// - Result c and status flags are captured on the next clk edge.
// - Leaf datapath block, fed by the operand/decode stage; its outputs feed the writeback/flag logic.
//
// PARAMETERS
// - WIDTH  default 8  operand/result width in bits; all arithmetic is modulo 2**WIDTH.
//
// PORTS
// - clk        in   1      single clock; all state updates on rising edge
// - rst        in   1      synchronous, active-high reset
// - in_valid   in   1      a/b/op are valid this cycle; a result is launched
// - a          in   WIDTH  operand A, unsigned (two's-complement for V/N flags)
// - b          in   WIDTH  operand B
// - op         in   2      opcode: 00 ADD, 01 AND, 10 OR, 11 XOR
// - c          out  WIDTH  registered result
// - out_valid  out  1      c/flags hold a result launched the previous cycle
// - flag_z     out  1      c == 0
// - flag_n     out  1      c[WIDTH-1]
// - flag_c     out  1      carry out of ADD; 0 for logic ops
// - flag_v     out  1      signed overflow of ADD; 0 for logic ops
//
// BEHAVIOUR
// - Reset, sampled on posedge clk while rst=1:
//   - c=0, out_valid=0, flag_z=1, flag_n=0, flag_c=0, flag_v=0.
//   - rst has priority over in_valid in the same cycle.
// - Latency: exactly 1 cycle. in_valid=1 at edge k gives c/flags at edge k and out_valid=1
//   until the next edge. No backpressure; a new op may be issued every cycle.
// - in_valid=0: c and flags hold their last values; out_valid falls to 0.
// - ADD: {carry,sum} = a + b, computed at WIDTH+1 bits; c = sum[WIDTH-1:0] (wrap-around).
//   - flag_c = carry.
//   - flag_v = (a[msb]==b[msb]) && (sum[msb]!=a[msb]).
// - AND / OR / XOR: bitwise over all WIDTH bits; flag_c = flag_v = 0.
// - flag_z and flag_n are always derived from the new c, for every op.
// - All 4 opcodes are defined, so no illegal-op handling is needed.
// - No X propagation from unused bits; all registers are reset.
//
// STRUCTURE
// - Package alu_pkg:
//   - localparam opcodes OP_ADD=2'b00, OP_AND=2'b01, OP_OR=2'b10, OP_XOR=2'b11.
//   - Typedef op_t (2-bit).
// - Sub-module alu_datapath: purely combinational.
//   - Inputs a, b, op.
//   - Outputs next result and next c/v/z/n flags.
// - alu top: instantiates alu_datapath and adds the output registers, the valid register
//   and the reset/hold logic.
//
// TESTING
// - Reset: rst=1 for 2 cycles -> c=0, out_valid=0, flag_z=1, all other flags 0.
// - ADD/AND pairs, each issued with in_valid=1, checked one cycle later:
//   - 8,6: ADD -> 14, AND -> 0 (flag_z=1).
//   - 3,2: ADD -> 5, AND -> 2.
//   - 1,1: ADD -> 2, AND -> 1.
//   - 1,5: ADD -> 6, AND -> 1.
//   - 10,2: ADD -> 12, AND -> 2.
// - Wrap/flags:
//   - 200+100 -> c=44, flag_c=1, flag_v=0.
//   - 100+100 -> c=200, flag_v=1, flag_n=1, flag_c=0.
//   - 255+1 -> c=0, flag_z=1, flag_c=1.
// - Logic ops:
//   - 0xF0 OR 0x0F -> 0xFF, flag_n=1.
//   - 0xAA XOR 0xAA -> 0, flag_z=1.
// - Hold/back-to-back:
//   - Issue ADD 1,1 then in_valid=0 for 3 cycles -> c stays 2, out_valid pulses 1 cycle only.
//   - Issue ops on consecutive cycles -> one result per cycle, in order.
// - Reset mid-stream: assert rst together with in_valid=1 -> reset values win; next op
//   after rst drops produces its normal result.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared opcode encoding for the registered ALU.
//
// Contents:
//   op_t     2-bit opcode type
//   OP_ADD   2'b00  wrap-around add, produces carry/overflow
//   OP_AND   2'b01  bitwise AND
//   OP_OR    2'b10  bitwise OR
//   OP_XOR   2'b11  bitwise XOR
package alu_pkg;

    typedef logic [1:0] op_t;

    localparam op_t OP_ADD = 2'b00;
    localparam op_t OP_AND = 2'b01;
    localparam op_t OP_OR  = 2'b10;
    localparam op_t OP_XOR = 2'b11;

endpackage

// File: rtl/alu_datapath.sv
// alu_datapath: purely combinational core of the ALU. Computes the next result and
// the next status flags for one operand pair; the top module registers them.
//
// Ports:
//   a, b     in   WIDTH  operands (unsigned; two's-complement view for v/n)
//   op       in   2      opcode (see alu_pkg)
//   res      out  WIDTH  result, modulo 2**WIDTH
//   flag_z   out  1      res == 0
//   flag_n   out  1      res msb
//   flag_c   out  1      carry out of ADD, 0 for logic ops
//   flag_v   out  1      signed overflow of ADD, 0 for logic ops
module alu_datapath
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    output logic [WIDTH-1:0] res,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_c,
    output logic             flag_v
);

    // One extra bit so the carry falls out of the add directly.
    logic [WIDTH:0] sum_ext;

    assign sum_ext = {1'b0, a} + {1'b0, b};

    always_comb begin
        res    = '0;
        flag_c = 1'b0;
        flag_v = 1'b0;
        case (op_t'(op))
            OP_ADD: begin
                res    = sum_ext[WIDTH-1:0];
                flag_c = sum_ext[WIDTH];
                // Overflow: like-signed operands producing a result of the other sign.
                flag_v = (a[WIDTH-1] == b[WIDTH-1]) && (sum_ext[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND: res = a & b;
            OP_OR:  res = a | b;
            OP_XOR: res = a ^ b;
            default: ;
        endcase
    end

    assign flag_z = (res == '0);
    assign flag_n = res[WIDTH-1];

endmodule

// File: rtl/alu.sv
// alu: registered WIDTH-bit arithmetic/logic unit with one cycle of latency.
// A result launched with in_valid=1 appears on c/flags at that clock edge and
// out_valid is high until the next edge. Without in_valid, c and flags hold.
//
// Ports:
//   clk        in   1      clock, rising edge
//   rst        in   1      synchronous active-high reset (wins over in_valid)
//   in_valid   in   1      launch an operation this cycle
//   a, b       in   WIDTH  operands
//   op         in   2      00 ADD, 01 AND, 10 OR, 11 XOR
//   c          out  WIDTH  registered result
//   out_valid  out  1      c/flags were updated at the last edge
//   flag_z/n/c/v  out 1    zero, negative, carry, overflow of the held result
module alu
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    output logic [WIDTH-1:0] c,
    output logic             out_valid,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_c,
    output logic             flag_v
);

    logic [WIDTH-1:0] dp_res;
    logic             dp_z;
    logic             dp_n;
    logic             dp_c;
    logic             dp_v;

    logic [WIDTH-1:0] c_d, c_q;
    logic             valid_d, valid_q;
    logic             z_d, z_q;
    logic             n_d, n_q;
    logic             cf_d, cf_q;
    logic             v_d, v_q;

    alu_datapath #(
        .WIDTH (WIDTH)
    ) u_datapath (
        .a      (a),
        .b      (b),
        .op     (op),
        .res    (dp_res),
        .flag_z (dp_z),
        .flag_n (dp_n),
        .flag_c (dp_c),
        .flag_v (dp_v)
    );

    always_comb begin
        c_d     = c_q;
        z_d     = z_q;
        n_d     = n_q;
        cf_d    = cf_q;
        v_d     = v_q;
        valid_d = in_valid;
        if (in_valid) begin
            c_d  = dp_res;
            z_d  = dp_z;
            n_d  = dp_n;
            cf_d = dp_c;
            v_d  = dp_v;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            c_q     <= '0;
            valid_q <= 1'b0;
            z_q     <= 1'b1;  // consistent with c == 0
            n_q     <= 1'b0;
            cf_q    <= 1'b0;
            v_q     <= 1'b0;
        end else begin
            c_q     <= c_d;
            valid_q <= valid_d;
            z_q     <= z_d;
            n_q     <= n_d;
            cf_q    <= cf_d;
            v_q     <= v_d;
        end
    end

    assign c         = c_q;
    assign out_valid = valid_q;
    assign flag_z    = z_q;
    assign flag_n    = n_q;
    assign flag_c    = cf_q;
    assign flag_v    = v_q;

endmodule

// File: tb/tb_alu.sv
// tb_alu: self-checking bench for alu. Directed cases plus randomized traffic,
// all checked against an arithmetic reference model kept here.
module tb_alu;

    localparam int W = 8;
    localparam int MOD = 1 << W;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [1:0]   op;
    logic [W-1:0] c;
    logic         out_valid;
    logic         flag_z;
    logic         flag_n;
    logic         flag_c;
    logic         flag_v;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state.
    int m_c;
    bit m_valid;
    bit m_z;
    bit m_n;
    bit m_cf;
    bit m_v;

    alu #(
        .WIDTH (W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .op        (op),
        .c         (c),
        .out_valid (out_valid),
        .flag_z    (flag_z),
        .flag_n    (flag_n),
        .flag_c    (flag_c),
        .flag_v    (flag_v)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int to_signed(input int u);
        return (u >= MOD / 2) ? u - MOD : u;
    endfunction

    // Update the model for one clock edge, from the specification's rules.
    task automatic model_edge(input bit r, input bit iv, input int ua, input int ub,
                              input int uop);
        int full;
        int ssum;
        if (r) begin
            m_c = 0; m_valid = 0; m_z = 1; m_n = 0; m_cf = 0; m_v = 0;
            return;
        end
        m_valid = iv;
        if (!iv) return;
        m_cf = 0;
        m_v  = 0;
        case (uop)
            0: begin
                full = ua + ub;
                m_c  = full % MOD;
                m_cf = (full >= MOD);
                ssum = to_signed(ua) + to_signed(ub);
                m_v  = (ssum > MOD / 2 - 1) || (ssum < -(MOD / 2));
            end
            1: m_c = ua & ub;
            2: m_c = ua | ub;
            default: m_c = ua ^ ub;
        endcase
        m_z = (m_c == 0);
        m_n = (m_c >= MOD / 2);
    endtask

    // Drive one cycle, let the edge happen, then compare every output with the model.
    task automatic step(input bit r, input bit iv, input int ua, input int ub, input int uop);
        rst      = r;
        in_valid = iv;
        a        = W'(ua);
        b        = W'(ub);
        op       = 2'(uop);
        @(posedge clk);
        #1;
        model_edge(r, iv, ua, ub, uop);
        check_eq("c", int'(c), m_c);
        check_eq("out_valid", int'(out_valid), int'(m_valid));
        check_eq("flag_z", int'(flag_z), int'(m_z));
        check_eq("flag_n", int'(flag_n), int'(m_n));
        check_eq("flag_c", int'(flag_c), int'(m_cf));
        check_eq("flag_v", int'(flag_v), int'(m_v));
    endtask

    int pairs_a[5] = '{8, 3, 1, 1, 10};
    int pairs_b[5] = '{6, 2, 1, 5, 2};
    int add_exp[5] = '{14, 5, 2, 6, 12};
    int and_exp[5] = '{0, 2, 1, 1, 2};

    initial begin
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; op = '0;
        m_c = 0; m_valid = 0; m_z = 1; m_n = 0; m_cf = 0; m_v = 0;

        // Reset for two cycles.
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        check_eq("rst_c", int'(c), 0);
        check_eq("rst_z", int'(flag_z), 1);
        check_eq("rst_valid", int'(out_valid), 0);

        // ADD/AND pairs.
        for (int i = 0; i < 5; i++) begin
            step(0, 1, pairs_a[i], pairs_b[i], 0);
            check_eq("pair_add", int'(c), add_exp[i]);
            step(0, 1, pairs_a[i], pairs_b[i], 1);
            check_eq("pair_and", int'(c), and_exp[i]);
            check_eq("pair_and_z", int'(flag_z), int'(and_exp[i] == 0));
        end

        // Wrap and flags.
        step(0, 1, 200, 100, 0);
        check_eq("wrap_c", int'(c), 44);
        check_eq("wrap_cf", int'(flag_c), 1);
        check_eq("wrap_v", int'(flag_v), 0);
        step(0, 1, 100, 100, 0);
        check_eq("ovf_c", int'(c), 200);
        check_eq("ovf_v", int'(flag_v), 1);
        check_eq("ovf_n", int'(flag_n), 1);
        check_eq("ovf_cf", int'(flag_c), 0);
        step(0, 1, 255, 1, 0);
        check_eq("zero_c", int'(c), 0);
        check_eq("zero_z", int'(flag_z), 1);
        check_eq("zero_cf", int'(flag_c), 1);

        // Logic ops.
        step(0, 1, 8'hF0, 8'h0F, 2);
        check_eq("or_c", int'(c), 8'hFF);
        check_eq("or_n", int'(flag_n), 1);
        step(0, 1, 8'hAA, 8'hAA, 3);
        check_eq("xor_c", int'(c), 0);
        check_eq("xor_z", int'(flag_z), 1);

        // Hold: one result, then three idle cycles.
        step(0, 1, 1, 1, 0);
        check_eq("hold_valid0", int'(out_valid), 1);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 55, 77, 3);
            check_eq("hold_c", int'(c), 2);
            check_eq("hold_valid", int'(out_valid), 0);
        end

        // Back-to-back issue.
        for (int i = 0; i < 8; i++) begin
            step(0, 1, i * 17, i * 29, i % 4);
            check_eq("b2b_valid", int'(out_valid), 1);
        end

        // Reset together with in_valid, then a normal op.
        step(1, 1, 100, 100, 0);
        check_eq("rst_win_c", int'(c), 0);
        check_eq("rst_win_valid", int'(out_valid), 0);
        check_eq("rst_win_z", int'(flag_z), 1);
        step(0, 1, 3, 2, 0);
        check_eq("post_rst_c", int'(c), 5);

        // Randomized traffic with occasional resets and idle cycles.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 31) == 0), ($urandom_range(0, 3) != 0),
                 int'($urandom_range(0, MOD - 1)), int'($urandom_range(0, MOD - 1)),
                 int'($urandom_range(0, 3)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
